// File: rtl/result_output_pkg.sv
// Shared constants, FSM state encoding and item indices for the result display path.
`default_nettype none

package result_output_pkg;

  localparam int RESULT_WIDTH = 14;
  localparam int ELEM_WIDTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  localparam logic [1:0] SEL_INTERCEPT = 2'd0;
  localparam logic [1:0] SEL_SLOPE     = 2'd1;
  localparam logic [1:0] SEL_DET       = 2'd2;

endpackage

`default_nettype wire

// File: rtl/result_digit_conv.sv
// Sequential subtract-10 converter: signed word -> sign + two saturating decimal digits.
`default_nettype none

module result_digit_conv #(
  parameter int RESULT_WIDTH = result_output_pkg::RESULT_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load,
  input  logic [RESULT_WIDTH-1:0]                  value,
  output logic                                     busy,
  output logic                                     sign,
  output logic [result_output_pkg::ELEM_WIDTH-1:0] tens,
  output logic [result_output_pkg::ELEM_WIDTH-1:0] ones,
  output logic                                     overflow
);
  import result_output_pkg::*;

  localparam logic [RESULT_WIDTH-1:0] TEN  = RESULT_WIDTH'(10);
  localparam logic [RESULT_WIDTH-1:0] ONE  = RESULT_WIDTH'(1);
  localparam logic [ELEM_WIDTH-1:0]   NINE = ELEM_WIDTH'(9);

  logic [RESULT_WIDTH-1:0] rem;
  logic [RESULT_WIDTH-1:0] mag;
  logic                    active;
  logic                    ge10;

  // Two's-complement negate; the most negative word maps onto 2^(W-1) unsigned.
  assign mag  = value[RESULT_WIDTH-1] ? (~value + ONE) : value;
  assign ge10 = (rem >= TEN);

  // Low during the final step so the sequencer leaves CONVERT on the same edge.
  assign busy = active & ge10 & (tens != NINE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      active   <= 1'b0;
      sign     <= 1'b0;
      tens     <= '0;
      ones     <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      rem      <= mag;
      active   <= 1'b1;
      sign     <= value[RESULT_WIDTH-1];
      tens     <= '0;
      overflow <= 1'b0;
    end else if (active) begin
      if (ge10 && (tens != NINE)) begin
        rem  <= rem - TEN;
        tens <= tens + ELEM_WIDTH'(1);
      end else if (ge10) begin
        overflow <= 1'b1;
        tens     <= NINE;
        ones     <= NINE;
        active   <= 1'b0;
      end else begin
        ones   <= rem[ELEM_WIDTH-1:0];
        active <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/result_output.sv
// Captures regression results and steps through intercept, slope and determinant for display.
`default_nettype none

module result_output #(
  parameter int RESULT_WIDTH = result_output_pkg::RESULT_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [2*RESULT_WIDTH-1:0]                result_in,
  input  logic [RESULT_WIDTH-1:0]                  det_in,
  input  logic                                     error_det,
  input  logic                                     error_values,
  input  logic                                     next,
  output logic                                     out_valid,
  output logic [1:0]                               out_sel,
  output logic                                     sign,
  output logic [result_output_pkg::ELEM_WIDTH-1:0] tens,
  output logic [result_output_pkg::ELEM_WIDTH-1:0] ones,
  output logic                                     overflow,
  output logic                                     err,
  output logic                                     busy,
  output logic                                     done
);
  import result_output_pkg::*;

  state_t                    state;
  logic                      next_d;
  logic                      next_rise;
  logic [2*RESULT_WIDTH-1:0] cap_result;
  logic [RESULT_WIDTH-1:0]   cap_det;
  logic                      conv_load;
  logic                      conv_busy;
  logic [RESULT_WIDTH-1:0]   conv_value;

  assign next_rise = next & ~next_d;
  assign out_valid = (state == ST_SHOW);
  assign busy      = (state != ST_IDLE);

  assign conv_load = ((state == ST_IDLE) && start) ||
                     ((state == ST_SHOW) && next_rise && (out_sel != SEL_DET));

  // The word loaded on an advance is the one after the currently shown item.
  always_comb begin
    conv_value = result_in[RESULT_WIDTH-1:0];
    if (state == ST_SHOW) begin
      if (out_sel == SEL_INTERCEPT) conv_value = cap_result[2*RESULT_WIDTH-1:RESULT_WIDTH];
      else                          conv_value = cap_det;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      next_d     <= 1'b0;
      cap_result <= '0;
      cap_det    <= '0;
      err        <= 1'b0;
      out_sel    <= SEL_INTERCEPT;
      done       <= 1'b0;
    end else begin
      next_d <= next;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cap_result <= result_in;
            cap_det    <= det_in;
            err        <= error_det | error_values;
            out_sel    <= SEL_INTERCEPT;
            state      <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (!conv_busy) state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (next_rise) begin
            if (out_sel != SEL_DET) begin
              out_sel <= out_sel + 2'd1;
              state   <= ST_CONVERT;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  result_digit_conv #(
    .RESULT_WIDTH(RESULT_WIDTH)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .load     (conv_load),
    .value    (conv_value),
    .busy     (conv_busy),
    .sign     (sign),
    .tens     (tens),
    .ones     (ones),
    .overflow (overflow)
  );

endmodule

`default_nettype wire

// File: tb/tb_result_output.sv
// Directed self-checking bench for result_output.
`default_nettype none

module tb_result_output;
  localparam int RW = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2*RW-1:0] result_in = '0;
  logic [RW-1:0]   det_in = '0;
  logic            error_det = 1'b0;
  logic            error_values = 1'b0;
  logic            next = 1'b0;
  logic            out_valid;
  logic [1:0]      out_sel;
  logic            sign;
  logic [3:0]      tens;
  logic [3:0]      ones;
  logic            overflow;
  logic            err;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_err = 0;

  // {out_valid, out_sel, sign, tens, ones, overflow, err, busy}
  logic [14:0] obs;
  assign obs = {out_valid, out_sel, sign, tens, ones, overflow, err, busy};

  result_output #(.RESULT_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .result_in(result_in), .det_in(det_in),
    .error_det(error_det), .error_values(error_values), .next(next),
    .out_valid(out_valid), .out_sel(out_sel), .sign(sign), .tens(tens), .ones(ones),
    .overflow(overflow), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Counts CONVERT cycles until out_valid; returns -1 if the bound expires.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0; next = 1'b0; error_det = 1'b0; error_values = 1'b0;
      if (out_valid) return;
      cyc++;
    end
    cyc = -1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 15'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got %b done=%b expected all zero", obs, done);
    end
    rst  = 1'b0;
    next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 15'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_no_advance: got %b done=%b expected all zero", obs, done);
    end
  endtask

  task automatic test_normal;
    int cyc;
    result_in = {-14'sd23, 14'sd5}; det_in = 14'd42; start = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 1 || obs !== {1'b1, 2'd0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL normal_item0: got cyc=%0d %b expected cyc=1 1_00_0_0000_0101_0_0_1", cyc, obs);
    end
    next = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 3 || obs !== {1'b1, 2'd1, 1'b1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL normal_item1: got cyc=%0d %b expected cyc=3 1_01_1_0010_0011_0_0_1", cyc, obs);
    end
    next = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 5 || obs !== {1'b1, 2'd2, 1'b0, 4'd4, 4'd2, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL normal_item2: got cyc=%0d %b expected cyc=5 1_10_0_0100_0010_0_0_1", cyc, obs);
    end
    next = 1'b1;
    @(negedge clk); next = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || obs !== {1'b0, 2'd2, 1'b0, 4'd4, 4'd2, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL normal_done: got done=%b %b expected done=1 0_10_0_0100_0010_0_0_0", done, obs);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL normal_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    result_in = {14'd150, 14'd0}; det_in = 14'h2000; start = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 1 || obs !== {1'b1, 2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL ovf_item0_zero: got cyc=%0d %b expected cyc=1 1_00_0_0000_0000_0_0_1", cyc, obs);
    end
    next = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 10 || obs !== {1'b1, 2'd1, 1'b0, 4'd9, 4'd9, 1'b1, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL ovf_slope150: got cyc=%0d %b expected cyc=10 1_01_0_1001_1001_1_0_1", cyc, obs);
    end
    next = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 10 || obs !== {1'b1, 2'd2, 1'b1, 4'd9, 4'd9, 1'b1, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL ovf_det_min: got cyc=%0d %b expected cyc=10 1_10_1_1001_1001_1_0_1", cyc, obs);
    end
    next = 1'b1;
    @(negedge clk); next = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL ovf_done: got %b expected 1", done);
    end
  endtask

  task automatic test_button_hold;
    int cyc;
    @(negedge clk);
    result_in = {14'd7, 14'd12}; det_in = 14'd95; start = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 2 || obs !== {1'b1, 2'd0, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL hold_item0: got cyc=%0d %b expected cyc=2 1_00_0_0001_0010_0_0_1", cyc, obs);
    end
    next = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 2'd1, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL hold_one_advance: got %b expected 1_01_0_0000_0111_0_0_1", obs);
    end
    next = 1'b0;
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_sel !== 2'd2) begin
      n_err++; $display("FAIL hold_in_convert: got valid=%b sel=%0d expected 0 2", out_valid, out_sel);
    end
    wait_valid(cyc);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || obs !== {1'b1, 2'd2, 1'b0, 4'd9, 4'd5, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL hold_no_queue: got done=%b %b expected 0 1_10_0_1001_0101_0_0_1", done, obs);
    end
    next = 1'b1;
    @(negedge clk); next = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL hold_done: got %b expected 1", done);
    end
  endtask

  task automatic test_flags_capture;
    int cyc;
    @(negedge clk);
    result_in = {14'd31, 14'd2}; det_in = -14'sd3; error_det = 1'b1; start = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL flag_item0: got %b expected 1_00_0_0000_0010_0_1_1", obs);
    end
    start = 1'b1; result_in = {14'd77, 14'd88}; det_in = 14'd9; error_values = 1'b1;
    @(negedge clk);
    start = 1'b0; error_values = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL busy_start_show: got %b expected 1_00_0_0000_0010_0_1_1", obs);
    end
    next = 1'b1;
    @(negedge clk); next = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_valid(cyc);
    n_cmp++;
    if (obs !== {1'b1, 2'd1, 1'b0, 4'd3, 4'd1, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL busy_start_convert: got %b expected 1_01_0_0011_0001_0_1_1", obs);
    end
    next = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 1 || obs !== {1'b1, 2'd2, 1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL flag_item2: got cyc=%0d %b expected cyc=1 1_10_1_0000_0011_0_1_1", cyc, obs);
    end
    next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b0, 2'd2, 1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL flag_idle_hold: got %b expected 0_10_1_0000_0011_0_1_0", obs);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    result_in = {14'd60, 14'd1}; det_in = 14'd0; error_values = 1'b1; start = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL rmid_item0: got %b expected 1_00_0_0000_0001_0_1_1", obs);
    end
    next = 1'b1;
    @(negedge clk); next = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 15'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL rmid_cleared: got %b done=%b expected all zero", obs, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next = 1'b1; @(negedge clk);
      next = 1'b0; @(negedge clk);
    end
    n_cmp++;
    if (obs !== 15'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL rmid_no_advance: got %b done=%b expected all zero", obs, done);
    end
    result_in = {14'd0, -14'sd45}; det_in = 14'd0; start = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 5 || obs !== {1'b1, 2'd0, 1'b1, 4'd4, 4'd5, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL rmid_restart: got cyc=%0d %b expected cyc=5 1_00_1_0100_0101_0_0_1", cyc, obs);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_overflow;
    test_button_hold;
    test_flags_capture;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
